fft_stage_sequencer: RTL and testbench
======================================

Name: fft_stage_sequencer

Overview:
- Sequences an in-place radix-2 decimation-in-time FFT over one shared butterfly unit and one dual-port sample memory.
- Issues one butterfly per cycle, stage by stage, and generates the read pair addresses and the twiddle ROM address.
- Generates the write-back addresses and write enable, delayed by the butterfly pipeline latency.
- Sits between the input-ready handshake of the FFT controller and the butterfly, twiddle ROM and memory datapath. Input data is already in bit-reversed order.

Parameters:
- LOG2N, 6, log2 of FFT length N (N=64 by default).
- BF_LATENCY, 3, butterfly pipeline depth in cycles from operand read to result write (≥1).
- ADDR_BITS, LOG2N, sample memory address width.
- ROM_BITS, LOG2N-1, twiddle ROM address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- ready_inputs  in  1  start request: all N samples are loaded.
- rd_valid  out  1  butterfly operands are being read this cycle.
- rd_addr_a  out  ADDR_BITS  upper-leg read address.
- rd_addr_b  out  ADDR_BITS  lower-leg read address.
- ROM_addr  out  ROM_BITS  twiddle index for the current butterfly.
- wr_en  out  1  write butterfly results this cycle.
- wr_addr_a  out  ADDR_BITS  upper-leg write address.
- wr_addr_b  out  ADDR_BITS  lower-leg write address.
- stage  out  $clog2(LOG2N)  current stage index.
- busy  out  1  transform in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0 at a rising edge):
  - FSM goes to IDLE.
  - All outputs become 0, including stage, the butterfly counter k and the whole write delay line.
  - Applies mid-transform: no pending write survives reset.
- FSM states: IDLE, ISSUE, DRAIN, DONE. All outputs are registered.
- IDLE:
  - ready_inputs=1 sampled at edge t → ISSUE from cycle t+1, with stage=0, k=0 and busy=1.
  - ready_inputs is ignored in every state except IDLE.
- ISSUE:
  - rd_valid=1 each cycle.
  - span=2^stage, grp=k>>stage, pos=k&(span-1).
  - rd_addr_a=(grp<<(stage+1))|pos, rd_addr_b=rd_addr_a+span.
  - ROM_addr=pos<<(LOG2N-1-stage).
  - k increments each cycle. After k=N/2-1: k←0 and go to DRAIN.
- DRAIN:
  - Lasts exactly BF_LATENCY cycles with rd_valid=0. This guarantees the last write of a stage lands before the first read of the next stage.
  - Then, if stage=LOG2N-1 → DONE. Otherwise stage increments and the FSM returns to ISSUE.
- DONE:
  - done=1 and busy=0 for one cycle, then IDLE.
  - stage holds LOG2N-1 until the next start.
- Write path:
  - wr_en, wr_addr_a and wr_addr_b equal rd_valid, rd_addr_a and rd_addr_b delayed by exactly BF_LATENCY cycles.
  - Implemented as a shift register with no stalls.
- Timing: numbering the first rd_valid cycle as 1, stage s issues in cycles 1+s·(N/2+BF_LATENCY) through s·(N/2+BF_LATENCY)+N/2.
  - Defaults: the last wr_en is in cycle 210 and done is in cycle 211.
  - Total = LOG2N·(N/2+BF_LATENCY)+1 cycles.
- Boundary conditions:
  - ready_inputs held high through DONE → the FSM re-enters IDLE and restarts on the following edge. Back-to-back transforms are legal.
  - rd_addr_b never wraps (it is always < N). Arithmetic is unsigned, ADDR_BITS wide.

Decomposition:
- Package fft_ctrl_pkg holds:
  - the state enumeration (IDLE=2'd0, ISSUE=2'd1, DRAIN=2'd2, DONE=2'd3);
  - derived constants HALF_N=2^(LOG2N-1) and STAGE_BITS;
  - a total-cycle-count constant for benches.
- One sub-module, fft_wr_delay_line: parameterised depth and width, synchronous active-low clear. It carries {valid, addr_a, addr_b}.

Test Plan:
- Reset mid-stage 2 (rst=0 for 1 cycle) → next cycle all outputs are 0 and the FSM is in IDLE. No wr_en occurs for the 3 cycles after reset. A new start gives a full 211-cycle run.
- Single start pulse → rd_valid high 32 cycles, low 3, repeated 6 times. done at cycle 211. wr_en count = 192.
- Address checks:
  - stage0 k=0 → a=0, b=1, ROM=0.
  - stage1 k=1 → a=1, b=3, ROM=16.
  - stage5 k=5 → a=5, b=37, ROM=5.
  - stage2 k=6 → a=10, b=14, ROM=16.
- Write alignment → for every issue cycle t, wr_en=1 at t+3 with identical addresses. Across each stage, the union of {a,b} covers 0..63 exactly once.
- ready_inputs toggling while busy → no effect on sequence or timing. ready_inputs held high through DONE → the second transform starts 2 cycles after done.
- BF_LATENCY=1 build → DRAIN is 1 cycle and done comes at cycle 6·33+1=199.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg
// Shared definitions for the FFT stage sequencer:
//   fft_state_e   sequencer FSM state encoding
//   half_n()      butterflies per stage for a given log2 length
//   stage_bits()  width of the stage index
//   total_cycles() cycles from first operand read to the done pulse
//   HALF_N, STAGE_BITS, TOTAL_CYCLES  values for the default N=64, latency 3 build
`timescale 1ns/1ps
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fft_state_e;

  function automatic int half_n(input int log2n);
    return 1 << (log2n - 1);
  endfunction

  function automatic int stage_bits(input int log2n);
    return (log2n > 1) ? $clog2(log2n) : 1;
  endfunction

  function automatic int total_cycles(input int log2n, input int bf_latency);
    return log2n * (half_n(log2n) + bf_latency) + 1;
  endfunction

  localparam int DEFAULT_LOG2N      = 6;
  localparam int DEFAULT_BF_LATENCY = 3;
  localparam int HALF_N             = half_n(DEFAULT_LOG2N);
  localparam int STAGE_BITS         = stage_bits(DEFAULT_LOG2N);
  localparam int TOTAL_CYCLES       = total_cycles(DEFAULT_LOG2N, DEFAULT_BF_LATENCY);

endpackage

// File: rtl/fft_wr_delay_line.sv
// fft_wr_delay_line
// Fixed-depth shift register that carries the read-side butterfly descriptor
// to the write side. No stalls: every entry advances every cycle.
// Ports:
//   clk_i    clock, rising edge
//   clr_n_i  synchronous active-low clear of every stage
//   d_i      descriptor entering the pipe
//   q_o      descriptor leaving the pipe DEPTH cycles later
`timescale 1ns/1ps
module fft_wr_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 13
) (
  input  logic             clk_i,
  input  logic             clr_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
// Sequences an in-place radix-2 DIT FFT over one butterfly unit: one
// butterfly per cycle, stage by stage, with read pair, twiddle and delayed
// write-back addressing. All outputs are registered.
// Ports:
//   clk           clock, rising edge
//   rst           synchronous reset, active-low
//   ready_inputs  start request (sampled in IDLE only)
//   rd_valid      operands read this cycle
//   rd_addr_a/b   upper/lower leg read addresses
//   ROM_addr      twiddle ROM index
//   wr_en         results written this cycle
//   wr_addr_a/b   upper/lower leg write addresses
//   stage         current stage index
//   busy          transform in progress
//   done          one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for ready_inputs
// ISSUE | one butterfly read per cycle, k = 0 .. N/2-1
// DRAIN | BF_LATENCY cycles without reads so the stage's writes land
// DONE  | done pulse, then back to IDLE
`timescale 1ns/1ps
module fft_stage_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int LOG2N      = 6,
  parameter int BF_LATENCY = 3,
  parameter int ADDR_BITS  = LOG2N,
  parameter int ROM_BITS   = LOG2N - 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ready_inputs,
  output logic                          rd_valid,
  output logic [ADDR_BITS-1:0]          rd_addr_a,
  output logic [ADDR_BITS-1:0]          rd_addr_b,
  output logic [ROM_BITS-1:0]           ROM_addr,
  output logic                          wr_en,
  output logic [ADDR_BITS-1:0]          wr_addr_a,
  output logic [ADDR_BITS-1:0]          wr_addr_b,
  output logic [stage_bits(LOG2N)-1:0]  stage,
  output logic                          busy,
  output logic                          done
);

  localparam int N_HALF   = half_n(LOG2N);
  localparam int ST_BITS  = stage_bits(LOG2N);
  localparam int K_BITS   = (LOG2N > 1) ? LOG2N - 1 : 1;
  localparam int DR_BITS  = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
  localparam int DL_WIDTH = 1 + 2 * ADDR_BITS;

  fft_state_e           state_q, state_d;
  logic [ST_BITS-1:0]   stage_q, stage_d;
  logic [K_BITS-1:0]    k_q, k_d;
  logic [DR_BITS-1:0]   drain_q, drain_d;

  logic                 rd_valid_q, rd_valid_d;
  logic [ADDR_BITS-1:0] rd_addr_a_q, rd_addr_a_d;
  logic [ADDR_BITS-1:0] rd_addr_b_q, rd_addr_b_d;
  logic [ROM_BITS-1:0]  rom_addr_q, rom_addr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [ADDR_BITS-1:0] span, grp, pos, base;
  logic                 issue_d;
  logic [DL_WIDTH-1:0]  wr_desc;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    drain_d = drain_q;

    case (state_q)
      IDLE: begin
        if (ready_inputs) begin
          state_d = ISSUE;
          stage_d = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        if (k_q == K_BITS'(N_HALF - 1)) begin
          k_d     = '0;
          drain_d = DR_BITS'(BF_LATENCY - 1);
          state_d = DRAIN;
        end else begin
          k_d = k_q + K_BITS'(1);
        end
      end
      DRAIN: begin
        if (drain_q == '0) begin
          if (stage_q == ST_BITS'(LOG2N - 1)) begin
            state_d = DONE;
          end else begin
            stage_d = stage_q + ST_BITS'(1);
            state_d = ISSUE;
          end
        end else begin
          drain_d = drain_q - DR_BITS'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Addresses are derived from the next k/stage so they can be registered
    // and line up with the registered rd_valid.
    span = ADDR_BITS'(1) << stage_d;
    grp  = ADDR_BITS'(k_d) >> stage_d;
    pos  = ADDR_BITS'(k_d) & (span - ADDR_BITS'(1));
    base = (grp << (int'(stage_d) + 1)) | pos;

    issue_d     = (state_d == ISSUE);
    rd_valid_d  = issue_d;
    rd_addr_a_d = issue_d ? base : '0;
    rd_addr_b_d = issue_d ? base + span : '0;
    rom_addr_d  = issue_d ? ROM_BITS'(pos << (LOG2N - 1 - int'(stage_d))) : '0;
    busy_d      = (state_d == ISSUE) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      stage_q     <= '0;
      k_q         <= '0;
      drain_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      rom_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      rom_addr_q  <= rom_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  fft_wr_delay_line #(
    .DEPTH (BF_LATENCY),
    .WIDTH (DL_WIDTH)
  ) u_wr_delay (
    .clk_i   (clk),
    .clr_n_i (rst),
    .d_i     ({rd_valid_q, rd_addr_a_q, rd_addr_b_q}),
    .q_o     (wr_desc)
  );

  assign rd_valid  = rd_valid_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign ROM_addr  = rom_addr_q;
  assign stage     = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign {wr_en, wr_addr_a, wr_addr_b} = wr_desc;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer
// Self-checking bench: two sequencer instances (butterfly latency 3 and 1)
// compared cycle by cycle against a reference schedule built from the
// group/position description of a radix-2 DIT FFT.
`timescale 1ns/1ps
module tb_fft_stage_sequencer;

  localparam int LOG2N = 6;
  localparam int NPTS  = 64;
  localparam int HALF  = 32;
  localparam int MAXC  = 300;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ready0 = 1'b0;
  logic ready1 = 1'b0;

  logic       rd_valid0, wr_en0, busy0, done0;
  logic [5:0] rd_a0, rd_b0, wr_a0, wr_b0;
  logic [4:0] rom0;
  logic [2:0] stage0;
  logic       rd_valid1, wr_en1, busy1, done1;
  logic [5:0] rd_a1, rd_b1, wr_a1, wr_b1;
  logic [4:0] rom1;
  logic [2:0] stage1;

  logic [35:0] obs0, obs1;
  logic [35:0] exp_vec [MAXC];
  logic [5:0]  cap_a [MAXC];
  logic [5:0]  cap_b [MAXC];
  logic [4:0]  cap_rom [MAXC];
  int          cov [8][NPTS];
  int          tot;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.LOG2N(6), .BF_LATENCY(3)) dut0 (
    .clk(clk), .rst(rst), .ready_inputs(ready0),
    .rd_valid(rd_valid0), .rd_addr_a(rd_a0), .rd_addr_b(rd_b0), .ROM_addr(rom0),
    .wr_en(wr_en0), .wr_addr_a(wr_a0), .wr_addr_b(wr_b0),
    .stage(stage0), .busy(busy0), .done(done0)
  );

  fft_stage_sequencer #(.LOG2N(6), .BF_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .ready_inputs(ready1),
    .rd_valid(rd_valid1), .rd_addr_a(rd_a1), .rd_addr_b(rd_b1), .ROM_addr(rom1),
    .wr_en(wr_en1), .wr_addr_a(wr_a1), .wr_addr_b(wr_b1),
    .stage(stage1), .busy(busy1), .done(done1)
  );

  assign obs0 = {rd_valid0, rd_a0, rd_b0, rom0, wr_en0, wr_a0, wr_b0, stage0, busy0, done0};
  assign obs1 = {rd_valid1, rd_a1, rd_b1, rom1, wr_en1, wr_a1, wr_b1, stage1, busy1, done1};

  // Reference schedule: stage s, group g, position p is issued at cycle
  // 1 + s*(N/2+lat) + g*span + p; writes repeat the reads lat cycles later.
  task automatic build_model(input int lat);
    int rv [MAXC];
    int ea [MAXC];
    int eb [MAXC];
    int er [MAXC];
    int period, span, c, wv, wa, wb, st, bz, dn;
    period = HALF + lat;
    tot = LOG2N * period + 1;
    for (int i = 0; i < MAXC; i++) begin
      rv[i] = 0; ea[i] = 0; eb[i] = 0; er[i] = 0;
    end
    for (int s = 0; s < LOG2N; s++) begin
      span = 1 << s;
      for (int g = 0; g < NPTS / (2 * span); g++) begin
        for (int p = 0; p < span; p++) begin
          c = 1 + s * period + g * span + p;
          rv[c] = 1;
          ea[c] = g * 2 * span + p;
          eb[c] = ea[c] + span;
          er[c] = p * (HALF / span);
        end
      end
    end
    for (int i = 0; i < MAXC; i++) begin
      wv = (i > lat) ? rv[i-lat] : 0;
      wa = (i > lat) ? ea[i-lat] : 0;
      wb = (i > lat) ? eb[i-lat] : 0;
      if (i >= 1 && i < tot) begin
        st = (i - 1) / period; bz = 1; dn = 0;
      end else begin
        st = LOG2N - 1; bz = 0; dn = (i == tot) ? 1 : 0;
      end
      exp_vec[i] = {1'(rv[i]), 6'(ea[i]), 6'(eb[i]), 5'(er[i]), 1'(wv), 6'(wa), 6'(wb),
                    3'(st), 1'(bz), 1'(dn)};
    end
  endtask

  task automatic do_start(input int which);
    repeat ($urandom_range(0, 4)) @(posedge clk);
    @(negedge clk);
    if (which == 1) ready1 = 1'b1; else ready0 = 1'b1;
    @(posedge clk);
  endtask

  // mode 0: ready dropped, 1: ready randomised while busy, 2: ready held high
  task automatic run_check(input int which, input int mode, input int last_c, input string tag,
                           output int rdc, output int wrc, output int donec);
    logic [35:0] o;
    logic        r;
    rdc = 0; wrc = 0; donec = -1;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      o = (which == 1) ? obs1 : obs0;
      checks++;
      if (o !== exp_vec[c]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, c, o, exp_vec[c]);
      end
      cap_a[c] = o[34:29]; cap_b[c] = o[28:23]; cap_rom[c] = o[22:18];
      if (o[35] === 1'b1) begin
        rdc++;
        cov[o[4:2]][o[34:29]]++;
        cov[o[4:2]][o[28:23]]++;
      end
      if (o[17] === 1'b1) wrc++;
      if (o[0] === 1'b1 && donec < 0) donec = c;
      case (mode)
        1:       r = (c <= tot) ? 1'($urandom_range(0, 1)) : 1'b0;
        2:       r = 1'b1;
        default: r = 1'b0;
      endcase
      if (which == 1) ready1 = r; else ready0 = r;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs0 !== 36'd0) begin errors++; $display("FAIL reset_dut0: got %h expected 0", obs0); end
    checks++;
    if (obs1 !== 36'd0) begin errors++; $display("FAIL reset_dut1: got %h expected 0", obs1); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (obs0 !== 36'd0) begin errors++; $display("FAIL idle_no_start: got %h expected 0", obs0); end
  endtask

  task automatic test_single_run();
    int rdc, wrc, donec, bad;
    build_model(3);
    for (int s = 0; s < 8; s++) for (int a = 0; a < NPTS; a++) cov[s][a] = 0;
    do_start(0);
    run_check(0, 0, tot + 2, "single_run", rdc, wrc, donec);
    checks++;
    if (rdc != 192) begin errors++; $display("FAIL rd_count: got %0d expected 192", rdc); end
    checks++;
    if (wrc != 192) begin errors++; $display("FAIL wr_count: got %0d expected 192", wrc); end
    checks++;
    if (donec != 211) begin errors++; $display("FAIL done_cycle: got %0d expected 211", donec); end
    checks++;
    if ({cap_a[1], cap_b[1], cap_rom[1]} !== {6'd0, 6'd1, 5'd0}) begin
      errors++; $display("FAIL addr_s0k0: got %0d/%0d/%0d expected 0/1/0", cap_a[1], cap_b[1], cap_rom[1]);
    end
    checks++;
    if ({cap_a[37], cap_b[37], cap_rom[37]} !== {6'd1, 6'd3, 5'd16}) begin
      errors++; $display("FAIL addr_s1k1: got %0d/%0d/%0d expected 1/3/16", cap_a[37], cap_b[37], cap_rom[37]);
    end
    checks++;
    if ({cap_a[181], cap_b[181], cap_rom[181]} !== {6'd5, 6'd37, 5'd5}) begin
      errors++; $display("FAIL addr_s5k5: got %0d/%0d/%0d expected 5/37/5", cap_a[181], cap_b[181], cap_rom[181]);
    end
    checks++;
    if ({cap_a[77], cap_b[77], cap_rom[77]} !== {6'd10, 6'd14, 5'd16}) begin
      errors++; $display("FAIL addr_s2k6: got %0d/%0d/%0d expected 10/14/16", cap_a[77], cap_b[77], cap_rom[77]);
    end
    for (int s = 0; s < LOG2N; s++) begin
      bad = 0;
      for (int a = 0; a < NPTS; a++) if (cov[s][a] != 1) bad++;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL coverage_stage%0d: %0d addresses not hit exactly once, expected 0", s, bad);
      end
    end
  endtask

  task automatic test_ready_toggle();
    int rdc, wrc, donec;
    build_model(3);
    do_start(0);
    run_check(0, 1, tot + 2, "ready_toggle", rdc, wrc, donec);
    checks++;
    if (donec != 211) begin errors++; $display("FAIL toggle_done_cycle: got %0d expected 211", donec); end
    checks++;
    if (wrc != 192) begin errors++; $display("FAIL toggle_wr_count: got %0d expected 192", wrc); end
  endtask

  task automatic test_back_to_back();
    int rdc, wrc, donec;
    build_model(3);
    do_start(0);
    run_check(0, 2, tot + 1, "b2b_first", rdc, wrc, donec);
    run_check(0, 0, tot + 2, "b2b_second", rdc, wrc, donec);
    checks++;
    if (donec != 211) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 211", donec); end
  endtask

  task automatic test_reset_mid();
    int rdc, wrc, donec, rc;
    build_model(3);
    rc = $urandom_range(71, 105);
    do_start(0);
    run_check(0, 0, rc, "pre_reset", rdc, wrc, donec);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (obs0 !== 36'd0) begin errors++; $display("FAIL mid_reset_outputs: got %h expected 0", obs0); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs0 !== 36'd0) begin
        errors++; $display("FAIL post_reset_quiet%0d: got %h expected 0", i, obs0);
      end
    end
    do_start(0);
    run_check(0, 0, tot + 2, "after_reset", rdc, wrc, donec);
    checks++;
    if (donec != 211) begin errors++; $display("FAIL after_reset_done: got %0d expected 211", donec); end
  endtask

  task automatic test_latency1();
    int rdc, wrc, donec;
    build_model(1);
    do_start(1);
    run_check(1, 0, tot + 2, "latency1", rdc, wrc, donec);
    checks++;
    if (donec != 199) begin errors++; $display("FAIL lat1_done_cycle: got %0d expected 199", donec); end
    checks++;
    if (wrc != 192) begin errors++; $display("FAIL lat1_wr_count: got %0d expected 192", wrc); end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_ready_toggle();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
